alu_issue_unit: RTL
===================

# alu_issue_unit

Sequential front end for the combinational `alu`. It buffers incoming 32-bit MIPS-format instructions in a small FIFO and owns the two architectural registers A (address 00000) and B (address 00001). It issues one instruction at a time to the ALU, writes results back to A/B, and presents each retired result, flags and branch decision on a valid/ready output port.

## Interface
- `DEPTH`, 4, instruction FIFO depth; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_valid`  in  1  instruction offered.
- `in_instr`  in  32  instruction word.
- `in_ready`  out  1  FIFO not full.
- `load_en`  in  1  preload A/B.
- `load_a`  in  32  value loaded into A.
- `load_b`  in  32  value loaded into B.
- `alu_instruction`  out  32  registered instruction to ALU.
- `alu_rega`  out  32  current A, driven combinationally from the register.
- `alu_regb`  out  32  current B, driven combinationally from the register.
- `alu_result`  in  32  ALU result.
- `alu_flags`  in  3  ALU flags {zero, negative, overflow}: bit2 zero, bit1 negative, bit0 overflow.
- `out_valid`  out  1  retired record valid.
- `out_ready`  in  1  consumer accepts record.
- `out_result`  out  32  value written back, or the raw ALU result if there is no write.
- `out_flags`  out  3  captured ALU flags.
- `out_branch`  out  1  branch taken (beq/bne only).
- `out_exc`  out  1  overflow exception; write suppressed.
- `out_wr`  out  1  a register was written.

## Operation
- FIFO: push on `in_valid && in_ready`. `in_ready = (count != DEPTH)`, based on count only.
- FSM states are IDLE, EXEC and RETIRE.
- IDLE:
  - If `load_en`: A←`load_a`, B←`load_b`, no pop. `load_en` has priority over issue.
  - Otherwise, if the FIFO is non-empty: pop the head into `alu_instruction`, go to EXEC.
  - `load_en` is ignored in EXEC and RETIRE.
- EXEC (one cycle): sample `alu_result`/`alu_flags` and perform writeback. Load the out_* registers, set `out_valid`, go to RETIRE.
- Writeback destination:
  - R-type (opcode 0): rd = `instr[15:11]`.
  - I-type: rt = `instr[20:16]`.
  - Write only if the destination is 00000 (A) or 00001 (B). Otherwise `out_wr=0`.
- Write value:
  - slt/sltu/slti/sltiu: `{31'b0, alu_flags[1]}`.
  - All other writing ops: `alu_result`.
- No write for:
  - beq (opcode 000100), bne (000101), sw (101011), lw (100011). lw/sw report the address in `out_result`.
  - Unknown opcode/func (`out_result = alu_result`).
- Branch decision:
  - beq: `out_branch = alu_flags[2]`.
  - bne: `out_branch = !alu_flags[2]`.
  - Otherwise 0.
- Overflow: add (func 100000), sub (100010) or addi (001000) with `alu_flags[0]=1` → no write, `out_exc=1`.
- RETIRE: hold all out_* registers stable until `out_ready`. On the handshake, `out_valid` drops. If the FIFO is non-empty, pop and go to EXEC; otherwise go to IDLE.

## Timing
- Reset: all outputs 0 (`alu_instruction`, A, B, out_* registers, `out_valid`). FIFO is empty, so `in_ready=1`. FSM is in IDLE.
- Latency: instruction pushed at cycle t → issued at t+1 → EXEC at t+2 → `out_valid` at t+3. A/B are updated at the t+2→t+3 edge.
- Throughput with `out_ready` held high: one instruction per 2 cycles.
- An EXEC-cycle writeback is visible on `alu_rega`/`alu_regb` from the next cycle. A following instruction always sees the updated value.
- Push and pop in the same cycle: count is unchanged, and pointers wrap modulo DEPTH.
- A push while full is dropped because `in_ready=0`. A pop from an empty FIFO never occurs.
- Reset asserted mid-operation: the in-flight instruction and FIFO contents are discarded, and all state returns to reset values immediately.

## Configuration
- `ALU_ISSUE_STATS_EN`: when defined, adds 32-bit outputs `stat_retired` and `stat_exc`.
  - `stat_retired` counts out handshakes. `stat_exc` counts handshakes with `out_exc=1`.
  - Both counters wrap at 2^32 and are cleared by `rst`.
- Without the macro, the ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Reset, then load A=5, B=7, push addu A←A+B (0x00010021) → `out_valid` 3 cycles after push, `out_result=12`, `out_wr=1`, A=12, B=7.
- A=3, B=10, push addi A←B+(-1) (0x2020FFFF) → `out_result=9`, A=9.
- A=B=0x55, push beq (0x10010004) then bne (0x14010004) → `out_branch`=1 then 0, `out_wr=0` both times, A/B unchanged.
- A stub ALU returns flags 3'b001 on add (0x00010020) → `out_exc=1`, `out_wr=0`, A unchanged. With `ALU_ISSUE_STATS_EN` defined, `stat_exc=1`.
- Hold `out_ready=0`, push DEPTH+2 instructions back-to-back:
  - `in_ready` falls once DEPTH+1 are accepted (one in flight).
  - The `out_result` records are held stable.
  - Releasing `out_ready` retires all in order, one every 2 cycles.
- Assert `rst` while in EXEC with 2 FIFO entries → all outputs 0, `in_ready=1` the next cycle, and no retire ever appears for the flushed instructions.

Source files
------------

// File: rtl/alu_issue_unit_if.sv
// +-----------------------------------------------------------------------------
// | alu_issue_unit_if : instruction, preload, ALU and retire bundle for alu_issue_unit
// | rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

interface alu_issue_unit_if;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        load_en;
  logic [31:0] load_a;
  logic [31:0] load_b;
  logic [31:0] alu_instruction;
  logic [31:0] alu_rega;
  logic [31:0] alu_regb;
  logic [31:0] alu_result;
  logic [2:0]  alu_flags;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;
  logic        out_branch;
  logic        out_exc;
  logic        out_wr;

  // Issue unit side
  modport slave (
    input  in_valid, in_instr, load_en, load_a, load_b, alu_result, alu_flags, out_ready,
    output in_ready, alu_instruction, alu_rega, alu_regb,
    output out_valid, out_result, out_flags, out_branch, out_exc, out_wr
  );

  // Environment side: instruction source, ALU and retire consumer
  modport master (
    output in_valid, in_instr, load_en, load_a, load_b, alu_result, alu_flags, out_ready,
    input  in_ready, alu_instruction, alu_rega, alu_regb,
    input  out_valid, out_result, out_flags, out_branch, out_exc, out_wr
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_unit.sv
// +-----------------------------------------------------------------------------
// | alu_issue_unit : FIFO-buffered issue/writeback front end for the MIPS alu
// | Optional ALU_ISSUE_STATS_EN adds retire/exception counters.  rev 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module alu_issue_unit #(
  parameter int DEPTH = 4
) (
  input  wire                clk,
  input  wire                rst,
  alu_issue_unit_if.slave    bus
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]        stat_retired,
  output logic [31:0]        stat_exc
`endif
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [C_CNT_W-1:0] C_FULL = C_CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXEC   = 2'd1,
    S_RETIRE = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]        r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [C_CNT_W-1:0] r_count;
  logic [31:0]        r_instr, r_a, r_b;
  logic               r_out_valid, r_out_branch, r_out_exc, r_out_wr;
  logic [31:0]        r_out_result;
  logic [2:0]         r_out_flags;

  logic w_push, w_pop, w_load, w_exec, w_hs, w_nonempty;

  assign w_nonempty = (r_count != '0);
  assign w_push     = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Preload wins over issue in IDLE; RETIRE chains straight into the next issue
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_exec      = 1'b0;
    w_hs        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_en) begin
          w_load = 1'b1;
        end else if (w_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = S_RETIRE;
      end
      S_RETIRE: begin
        if (bus.out_ready) begin
          w_hs = 1'b1;
          if (w_nonempty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_EXEC;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_dest;
  logic        w_rtype, w_known, w_nowr, w_slt, w_ovf_op, w_beq, w_bne;
  logic        w_exc, w_wr, w_branch;
  logic [31:0] w_val;

  assign w_op    = r_instr[31:26];
  assign w_fn    = r_instr[5:0];
  assign w_rtype = (w_op == 6'b000000);
  assign w_dest  = w_rtype ? r_instr[15:11] : r_instr[20:16];

  always_comb begin
    w_known  = 1'b0;
    w_nowr   = 1'b0;
    w_slt    = 1'b0;
    w_ovf_op = 1'b0;
    w_beq    = 1'b0;
    w_bne    = 1'b0;
    if (w_rtype) begin
      case (w_fn)
        6'b100000, 6'b100010: begin w_known = 1'b1; w_ovf_op = 1'b1; end
        6'b101010, 6'b101011: begin w_known = 1'b1; w_slt = 1'b1; end
        6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
        6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111:
          w_known = 1'b1;
        default: ;
      endcase
    end else begin
      case (w_op)
        6'b001000:                       begin w_known = 1'b1; w_ovf_op = 1'b1; end
        6'b001010, 6'b001011:            begin w_known = 1'b1; w_slt = 1'b1; end
        6'b000100:                       begin w_known = 1'b1; w_nowr = 1'b1; w_beq = 1'b1; end
        6'b000101:                       begin w_known = 1'b1; w_nowr = 1'b1; w_bne = 1'b1; end
        6'b100011, 6'b101011:            begin w_known = 1'b1; w_nowr = 1'b1; end
        6'b001001, 6'b001100, 6'b001101, 6'b001110, 6'b001111:
          w_known = 1'b1;
        default: ;
      endcase
    end
  end

  // Only destinations 00000 (A) and 00001 (B) exist architecturally
  assign w_exc    = w_ovf_op && bus.alu_flags[0];
  assign w_wr     = w_known && !w_nowr && !w_exc && (w_dest[4:1] == 4'b0000);
  assign w_val    = w_slt ? {31'b0, bus.alu_flags[1]} : bus.alu_result;
  assign w_branch = (w_beq && bus.alu_flags[2]) || (w_bne && !bus.alu_flags[2]);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.in_instr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_instr      <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_flags  <= '0;
      r_out_branch <= 1'b0;
      r_out_exc    <= 1'b0;
      r_out_wr     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + C_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop) r_instr <= r_mem[r_rd_ptr];
      if (w_load) begin
        r_a <= bus.load_a;
        r_b <= bus.load_b;
      end
      if (w_exec) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_wr ? w_val : bus.alu_result;
        r_out_flags  <= bus.alu_flags;
        r_out_branch <= w_branch;
        r_out_exc    <= w_exc;
        r_out_wr     <= w_wr;
        if (w_wr) begin
          if (w_dest[0]) r_b <= w_val;
          else           r_a <= w_val;
        end
      end
      if (w_hs) r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready        = (r_count != C_FULL);
  assign bus.alu_instruction = r_instr;
  assign bus.alu_rega        = r_a;
  assign bus.alu_regb        = r_b;
  assign bus.out_valid       = r_out_valid;
  assign bus.out_result      = r_out_result;
  assign bus.out_flags       = r_out_flags;
  assign bus.out_branch      = r_out_branch;
  assign bus.out_exc         = r_out_exc;
  assign bus.out_wr          = r_out_wr;

`ifdef ALU_ISSUE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_retired <= '0;
      stat_exc     <= '0;
    end else if (w_hs) begin
      stat_retired <= stat_retired + 32'd1;
      if (r_out_exc) stat_exc <= stat_exc + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire
